pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline; drives the control inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 13 +
 rtl/pipeline_hazard_ctrl_if.sv | 37 +++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the hard-wired zero register index.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } ctrl_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master = datapath side (supplies hazard info, consumes stall/flush controls)
// slave  = controller side.
interface pipeline_hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] ex_rd;
    logic       ex_mem_read_ena;
    logic       ex_redirect;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_stall;
    logic       if_id_stall;
    logic       if_id_flush;
    logic       id_ex_stall;
    logic       id_ex_flush;
    logic       ex_mem_stall;
    logic       mem_wb_flush;
    logic       mem_timeout;
    logic [1:0] ctrl_state;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd,
               ex_mem_read_ena, ex_redirect, mem_req, mem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_flush, mem_timeout, ctrl_state
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd,
               ex_mem_read_ena, ex_redirect, mem_req, mem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_flush, mem_timeout, ctrl_state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: flags when the load in EX writes a
// register that the instruction in ID reads. x0 never creates a dependency.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic       ex_mem_read_ena,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    output logic       hazard
);
    logic [4:0] src_idx [2];
    logic [1:0] src_used;
    logic [1:0] src_match;

    assign src_idx[0]  = id_rs1;
    assign src_idx[1]  = id_rs2;
    assign src_used[0] = id_rs1_used;
    assign src_used[1] = id_rs2_used;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_used[gi] && (src_idx[gi] == ex_rd);
        end
    endgenerate

    assign hazard = ex_mem_read_ena && (ex_rd != REG_X0) && (|src_match);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait FSM with a
// watchdog, load-use bubble insertion and redirect squashing.
// Optional macro PIPE_CTRL_PERF_EN adds stall-cycle and flush counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]      perf_stall_cycles,
    output logic [CNT_W-1:0]      perf_flush_cnt
`endif
);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(MEM_TIMEOUT);
    localparam bit               WD_EN       = (MEM_TIMEOUT != 0);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;
    logic             timeout_q, timeout_d;
    logic             hazard, freeze;
    logic             pc_stall, if_id_stall, if_id_flush, id_ex_stall;
    logic             id_ex_flush, ex_mem_stall, mem_wb_flush;

    load_use_detect u_load_use_detect (
        .ex_mem_read_ena (bus.ex_mem_read_ena),
        .ex_rd           (bus.ex_rd),
        .id_rs1          (bus.id_rs1),
        .id_rs2          (bus.id_rs2),
        .id_rs1_used     (bus.id_rs1_used),
        .id_rs2_used     (bus.id_rs2_used),
        .hazard          (hazard)
    );

    // Wait counter sticks at all-ones instead of wrapping.
    assign wait_cnt_inc = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic: enter MEM_WAIT on an unfinished access, leave on
    // ready, or park in ERROR once the watchdog limit is reached.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_d = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (WD_EN && (wait_cnt_inc >= TIMEOUT_LIM)) begin
                        state_d   = ST_ERROR;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign freeze = ((state_q == ST_RUN) && bus.mem_req && !bus.mem_ready) ||
                    ((state_q == ST_MEM_WAIT) && !bus.mem_ready) ||
                    (state_q == ST_ERROR);

    // Output decode: freeze beats redirect, redirect beats load-use (the ID
    // instruction is squashed anyway); everything drops while reset is high.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        if (!reset) begin
            if (freeze) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (bus.ex_redirect) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (hazard) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_flush  = 1'b1;
            end
        end
    end

    assign bus.pc_stall     = pc_stall;
    assign bus.if_id_stall  = if_id_stall;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_stall  = id_ex_stall;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_stall = ex_mem_stall;
    assign bus.mem_wb_flush = mem_wb_flush;
    assign bus.mem_timeout  = timeout_q && !reset;
    assign bus.ctrl_state   = reset ? ST_RUN : state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_stall_q, perf_flush_q;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (pc_stall)    perf_stall_q <= perf_stall_q + CNT_W'(1);
            if (if_id_flush) perf_flush_q <= perf_flush_q + CNT_W'(1);
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_cnt    = perf_flush_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (watchdog limit set to 4).
// Define PIPE_CTRL_PERF_EN to also exercise the perf counters.
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    pipeline_hazard_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_cnt;
`endif

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_cnt    (perf_flush_cnt)
`endif
    );

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
    logic [6:0] ctl;
    assign ctl = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall,
                  bus.id_ex_flush, bus.ex_mem_stall, bus.mem_wb_flush};

    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_FREEZE = 7'b1101011;
    localparam logic [6:0] C_REDIR  = 7'b0010100;
    localparam logic [6:0] C_LU     = 7'b1100100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
        bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
        bus.ex_rd = 5'd0; bus.ex_mem_read_ena = 1'b0;
        bus.ex_redirect = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.mem_req = 1'b1;
        next_cycle();
        #2;
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL reset_outs: ctl=%b expected %b", ctl, C_NONE); end
        next_cycle();
        bus.mem_req = 1'b0;
        reset = 1'b0;
        #2;
        checks++;
        if (bus.ctrl_state !== 2'd0) begin errors++; $display("FAIL reset_state: ctrl_state=%0d expected 0", bus.ctrl_state); end
        checks++;
        if (bus.mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: mem_timeout=%b expected 0", bus.mem_timeout); end
        $display("reset: ctl=%b state=%0d timeout=%b", ctl, bus.ctrl_state, bus.mem_timeout);
    endtask

    task automatic test_load_use();
        next_cycle();
        bus.ex_mem_read_ena = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1;
        #2;
        checks++;
        if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs1: ctl=%b expected %b", ctl, C_LU); end
        $display("load-use rs1=x5: ctl=%b", ctl);
        next_cycle();
        idle_inputs();
        #2;
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL lu_clear: ctl=%b expected %b", ctl, C_NONE); end
        next_cycle();
        bus.ex_mem_read_ena = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_rs1_used = 1'b1;
        #2;
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL lu_x0: ctl=%b expected %b", ctl, C_NONE); end
        $display("load-use x0: ctl=%b", ctl);
        next_cycle();
        bus.ex_rd = 5'd7; bus.id_rs1 = 5'd3; bus.id_rs2 = 5'd7; bus.id_rs2_used = 1'b1;
        #2;
        checks++;
        if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs2: ctl=%b expected %b", ctl, C_LU); end
        next_cycle();
        bus.id_rs2_used = 1'b0;
        #2;
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL lu_rs2_unused: ctl=%b expected %b", ctl, C_NONE); end
        next_cycle();
        bus.id_rs2_used = 1'b1; bus.ex_mem_read_ena = 1'b0;
        #2;
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL lu_not_load: ctl=%b expected %b", ctl, C_NONE); end
        $display("rs2 cases done: ctl=%b", ctl);
        idle_inputs();
    endtask

    task automatic test_redirect_priority();
        next_cycle();
        bus.ex_mem_read_ena = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1;
        bus.ex_redirect = 1'b1;
        #2;
        checks++;
        if (ctl !== C_REDIR) begin errors++; $display("FAIL redirect_prio: ctl=%b expected %b", ctl, C_REDIR); end
        $display("redirect+load-use: ctl=%b", ctl);
        idle_inputs();
    endtask

    task automatic test_freeze();
        logic [1:0] exp_state [4];
        exp_state = '{2'd0, 2'd1, 2'd1, 2'd1};
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus.mem_req   = 1'b1;
            bus.mem_ready = (i == 3);
            #2;
            checks++;
            if (ctl !== ((i == 3) ? C_NONE : C_FREEZE)) begin
                errors++;
                $display("FAIL freeze_c%0d: ctl=%b expected %b", i + 1, ctl, (i == 3) ? C_NONE : C_FREEZE);
            end
            checks++;
            if (bus.ctrl_state !== exp_state[i]) begin
                errors++;
                $display("FAIL freeze_state_c%0d: ctrl_state=%0d expected %0d", i + 1, bus.ctrl_state, exp_state[i]);
            end
            $display("freeze cycle %0d: ctl=%b state=%0d", i + 1, ctl, bus.ctrl_state);
        end
        next_cycle();
        idle_inputs();
        #2;
        checks++;
        if (bus.ctrl_state !== 2'd0) begin errors++; $display("FAIL freeze_back_run: ctrl_state=%0d expected 0", bus.ctrl_state); end
    endtask

    task automatic test_redirect_in_wait();
        next_cycle();
        bus.mem_req = 1'b1; bus.mem_ready = 1'b0; bus.ex_redirect = 1'b1;
        #2;
        checks++;
        if (ctl !== C_FREEZE) begin errors++; $display("FAIL wait_redir_c1: ctl=%b expected %b", ctl, C_FREEZE); end
        next_cycle();
        bus.ex_mem_read_ena = 1'b1; bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_rs1_used = 1'b1;
        #2;
        checks++;
        if (ctl !== C_FREEZE) begin errors++; $display("FAIL wait_redir_c2: ctl=%b expected %b", ctl, C_FREEZE); end
        next_cycle();
        bus.mem_ready = 1'b1;
        #2;
        checks++;
        if (ctl !== C_REDIR) begin errors++; $display("FAIL wait_redir_release: ctl=%b expected %b", ctl, C_REDIR); end
        $display("redirect on release: ctl=%b", ctl);
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_near_timeout();
        // One RUN cycle + 3 MEM_WAIT cycles, then ready: must not trip at limit 4.
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        end
        next_cycle();
        bus.mem_ready = 1'b1;
        #2;
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL near_to_release: ctl=%b expected %b", ctl, C_NONE); end
        next_cycle();
        idle_inputs();
        #2;
        checks++;
        if ({bus.mem_timeout, bus.ctrl_state} !== 3'b000) begin
            errors++;
            $display("FAIL near_to_state: timeout=%b state=%0d expected 0/0", bus.mem_timeout, bus.ctrl_state);
        end
        $display("near timeout: state=%0d timeout=%b", bus.ctrl_state, bus.mem_timeout);
    endtask

    task automatic test_timeout();
        // Cycle 1 in RUN, cycles 2..5 are the 4 MEM_WAIT cycles.
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        end
        #2;
        checks++;
        if ({bus.mem_timeout, bus.ctrl_state} !== 3'b001) begin
            errors++;
            $display("FAIL to_before: timeout=%b state=%0d expected 0/1", bus.mem_timeout, bus.ctrl_state);
        end
        next_cycle();
        #2;
        checks++;
        if ({bus.mem_timeout, bus.ctrl_state} !== 3'b110) begin
            errors++;
            $display("FAIL to_error: timeout=%b state=%0d expected 1/2", bus.mem_timeout, bus.ctrl_state);
        end
        checks++;
        if (ctl !== C_FREEZE) begin errors++; $display("FAIL to_stalls: ctl=%b expected %b", ctl, C_FREEZE); end
        $display("timeout: state=%0d timeout=%b ctl=%b", bus.ctrl_state, bus.mem_timeout, ctl);
        next_cycle();
        bus.mem_ready = 1'b1; bus.mem_req = 1'b0;
        #2;
        checks++;
        if ((ctl !== C_FREEZE) || (bus.ctrl_state !== 2'd2)) begin
            errors++;
            $display("FAIL to_held: ctl=%b state=%0d expected %b/2", ctl, bus.ctrl_state, C_FREEZE);
        end
        next_cycle();
        reset = 1'b1;
        #2;
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL to_reset_outs: ctl=%b expected %b", ctl, C_NONE); end
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        #2;
        checks++;
        if ({bus.mem_timeout, bus.ctrl_state} !== 3'b000) begin
            errors++;
            $display("FAIL to_after_reset: timeout=%b state=%0d expected 0/0", bus.mem_timeout, bus.ctrl_state);
        end
        $display("after reset: state=%0d timeout=%b", bus.ctrl_state, bus.mem_timeout);
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #2;
        checks++;
        if ({perf_stall_cycles, perf_flush_cnt} !== 64'd0) begin
            errors++;
            $display("FAIL perf_reset: stall=%0d flush=%0d expected 0/0", perf_stall_cycles, perf_flush_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            bus.ex_mem_read_ena = 1'b1; bus.ex_rd = 5'd4; bus.id_rs2 = 5'd4; bus.id_rs2_used = 1'b1;
            next_cycle();
            idle_inputs();
        end
        next_cycle();
        bus.ex_redirect = 1'b1;
        next_cycle();
        idle_inputs();
        #2;
        checks++;
        if (perf_stall_cycles !== 32'd2) begin errors++; $display("FAIL perf_stall: got %0d expected 2", perf_stall_cycles); end
        checks++;
        if (perf_flush_cnt !== 32'd1) begin errors++; $display("FAIL perf_flush: got %0d expected 1", perf_flush_cnt); end
        $display("perf: stall=%0d flush=%0d", perf_stall_cycles, perf_flush_cnt);
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_redirect_priority();
        test_freeze();
        test_redirect_in_wait();
        test_near_timeout();
        test_timeout();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
